cache_bus_arbiter: RTL

Shares the single system-bus master port between the instruction cache (requester 0) and the data cache (requester 1). Each cache keeps its existing bus-side handshake (reqcyc/reqack/respcyc/respack with 64-bit data and 13-bit tag). The arbiter grants one cache at a time, holds the grant for the whole line transaction (address phase plus the response burst), and steers response beats only to the owning cache. It sits between the two cache instances and the top-level bus pins.

---
 rtl/cache_bus_arbiter_pkg.sv | 32 +++
 rtl/cache_bus_arbiter_if.sv | 30 +++
 rtl/cache_bus_arbiter_pick2.sv | 32 +++
 rtl/cache_bus_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_bus_pkg
//   Shared definitions for the icache/dcache system-bus arbiter:
//   - arb_state_t        : arbiter FSM state encoding
//   - REQ_ICACHE/DCACHE  : requester ids (also the owner register encoding)
//   - SYSBUS_* constants : tag field values both caches place in reqtag
//   - sysbus_tag()       : builds a 13-bit tag {rw, id[7:0], kind[3:0]}
// -----------------------------------------------------------------------------
package cache_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   localparam logic REQ_ICACHE = 1'b0;
   localparam logic REQ_DCACHE = 1'b1;

   // Tag fields: bit 12 is the read/write flag, bits 3:0 the target kind.
   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic       SYSBUS_WRITE  = 1'b0;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

   function automatic logic [12:0] sysbus_tag(input logic       rw,
                                              input logic [7:0] id,
                                              input logic [3:0] kind);
      return {rw, id, kind};
   endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_bus_if
//   One reqcyc/reqack/respcyc/respack bus channel.
//   master : issues requests (drives reqcyc, req, reqtag, respack)
//   slave  : serves requests (drives reqack, respcyc, resp, resptag)
//   The arbiter is a slave towards each cache and a master towards the bus.
// -----------------------------------------------------------------------------
interface cache_bus_if #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 13
);
   logic              reqcyc;
   logic              reqack;
   logic [DATA_W-1:0] req;
   logic [TAG_W-1:0]  reqtag;
   logic              respcyc;
   logic              respack;
   logic [DATA_W-1:0] resp;
   logic [TAG_W-1:0]  resptag;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );
endinterface

// File: rtl/cache_bus_arbiter_pick2.sv
// -----------------------------------------------------------------------------
// arb_pick2
//   Combinational two-way picker.
//   i_req        : request vector, bit 0 icache, bit 1 dcache
//   i_last_owner : requester served most recently
//   i_rr_mode    : 1 = tie goes to the port that was not served last,
//                  0 = tie goes to dcache
//   o_win        : one-hot winner, 0 when nobody requests
// -----------------------------------------------------------------------------
module arb_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_last_owner,
   input  logic       i_rr_mode,
   output logic [1:0] o_win
);

   always_comb begin
      o_win = 2'b00;
      case (i_req)
         2'b01:   o_win = 2'b01;
         2'b10:   o_win = 2'b10;
         2'b11: begin
            if (i_rr_mode)
               o_win = i_last_owner ? 2'b01 : 2'b10;
            else
               o_win = 2'b10;
         end
         default: o_win = 2'b00;
      endcase
   end

endmodule

// File: rtl/cache_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cache_bus_arbiter
//   Shares the system-bus master port between the icache (requester 0) and
//   the dcache (requester 1). One cache owns the bus for a whole line
//   transaction (address phase + response burst); response beats are steered
//   only to the owner. Handshakes pass through combinationally.
//
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
//   otherwise dcache has fixed priority over icache.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   s_icache       : icache channel (slave side)
//   s_dcache       : dcache channel (slave side)
//   m_bus          : system-bus channel (master side)
//   o_grant        : one-hot current owner, 0 when idle
//   o_stray_resp   : one-cycle pulse after a bus beat arrives with nothing
//                    pending (IDLE or REQ)
// -----------------------------------------------------------------------------
module cache_bus_arbiter
   import cache_bus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = 8
) (
   input  logic        clk,
   input  logic        reset,
   cache_bus_if.slave  s_icache,
   cache_bus_if.slave  s_dcache,
   cache_bus_if.master m_bus,
   output logic [1:0]  o_grant,
   output logic        o_stray_resp
);

   localparam int CW = $clog2(BEATS) + 1;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_REQ  = REQ;
   localparam logic [1:0] ST_WAIT = WAIT;
   localparam logic [1:0] ST_RESP = RESP;

   localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);
   localparam logic [CW-1:0] SAT_CNT  = CW'(BEATS);

`ifdef ARB_ROUND_ROBIN_EN
   localparam logic RR_MODE = 1'b1;
`else
   localparam logic RR_MODE = 1'b0;
`endif

   logic [1:0]    r_state;
   logic          r_owner;
   logic          r_last_owner;
   logic [CW-1:0] r_beat;
   logic          r_stray;

   logic [1:0]                w_c_reqcyc;
   logic [1:0]                w_c_respack;
   logic [1:0]                w_c_reqack;
   logic [1:0]                w_c_respcyc;
   logic [1:0]                w_win;
   logic [1:0]                w_grant;
   logic                      w_own_reqcyc;
   logic                      w_own_respack;
   logic                      w_bus_reqcyc;
   logic                      w_bus_respack;
   logic [BUS_DATA_WIDTH-1:0] w_bus_req;
   logic [BUS_TAG_WIDTH-1:0]  w_bus_reqtag;

   assign w_c_reqcyc  = {s_dcache.reqcyc,  s_icache.reqcyc};
   assign w_c_respack = {s_dcache.respack, s_icache.respack};

   assign w_own_reqcyc  = w_c_reqcyc[r_owner];
   assign w_own_respack = w_c_respack[r_owner];

   arb_pick2 u_pick (
      .i_req        (w_c_reqcyc),
      .i_last_owner (r_last_owner),
      .i_rr_mode    (RR_MODE),
      .o_win        (w_win)
   );

   // ---------------------------------------------------------------------------
   // State, owner, beat counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_owner      <= REQ_ICACHE;
         r_last_owner <= REQ_DCACHE;
         r_beat       <= '0;
         r_stray      <= 1'b0;
      end else begin
         // Beats outside WAIT/RESP belong to no transaction.
         r_stray <= m_bus.respcyc && (r_state == ST_IDLE || r_state == ST_REQ);

         case (r_state)
            ST_IDLE: begin
               if (|w_c_reqcyc) begin
                  r_owner <= w_win[1];
                  r_beat  <= '0;
                  r_state <= ST_REQ;
               end
            end

            ST_REQ: begin
               // A withdrawn request aborts without touching last_owner, so
               // the aborting cache is not treated as served.
               if (!w_own_reqcyc)
                  r_state <= ST_IDLE;
               else if (m_bus.reqack)
                  r_state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (m_bus.respcyc) begin
                  r_beat <= CW'(1);
                  if (BEATS == 1) begin
                     r_state      <= ST_IDLE;
                     r_last_owner <= r_owner;
                  end else begin
                     r_state <= ST_RESP;
                  end
               end
            end

            ST_RESP: begin
               if (!m_bus.respcyc) begin
                  // Short burst: the bus stopped early.
                  r_state      <= ST_IDLE;
                  r_last_owner <= r_owner;
               end else begin
                  if (r_beat != SAT_CNT)
                     r_beat <= r_beat + 1'b1;
                  // Leaving on the last beat keeps any further beats out of
                  // the owner's line; they show up as stray instead.
                  if (r_beat >= LAST_IDX) begin
                     r_state      <= ST_IDLE;
                     r_last_owner <= r_owner;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Combinational steering: only the owner sees handshakes.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_grant       = 2'b00;
      w_bus_reqcyc  = 1'b0;
      w_bus_req     = '0;
      w_bus_reqtag  = '0;
      w_bus_respack = 1'b0;
      w_c_reqack    = 2'b00;
      w_c_respcyc   = 2'b00;
      case (r_state)
         ST_REQ: begin
            w_grant[r_owner]    = 1'b1;
            w_bus_reqcyc        = w_own_reqcyc;
            w_bus_req           = r_owner ? s_dcache.req    : s_icache.req;
            w_bus_reqtag        = r_owner ? s_dcache.reqtag : s_icache.reqtag;
            w_c_reqack[r_owner] = m_bus.reqack;
         end
         ST_WAIT, ST_RESP: begin
            w_grant[r_owner]     = 1'b1;
            w_c_respcyc[r_owner] = m_bus.respcyc;
            w_bus_respack        = w_own_respack;
         end
         default: ;
      endcase
   end

   assign m_bus.reqcyc  = w_bus_reqcyc;
   assign m_bus.req     = w_bus_req;
   assign m_bus.reqtag  = w_bus_reqtag;
   assign m_bus.respack = w_bus_respack;

   assign s_icache.reqack  = w_c_reqack[0];
   assign s_icache.respcyc = w_c_respcyc[0];
   assign s_dcache.reqack  = w_c_reqack[1];
   assign s_dcache.respcyc = w_c_respcyc[1];

   // Response data/tag are broadcast; respcyc alone tells a cache it is addressed.
   assign s_icache.resp    = m_bus.resp;
   assign s_icache.resptag = m_bus.resptag;
   assign s_dcache.resp    = m_bus.resp;
   assign s_dcache.resptag = m_bus.resptag;

   assign o_grant      = w_grant;
   assign o_stray_resp = r_stray;

endmodule
